block_stream_emitter: RTL and testbench

//  Token-to-character transmitter for the begin/end block checker datapath.

---
 rtl/block_stream_emitter_if.sv | 26 ++
 rtl/block_stream_emitter.sv | 160 ++++++++++++++++
 tb/tb_block_stream_emitter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/block_stream_emitter_if.sv
// Command and character-link signals of block_stream_emitter.
// The master side issues token commands; the slave side (the emitter) produces characters.
interface block_stream_emitter_if #(
  parameter int DEPTH_W = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [3:0]         cmd_len;
  logic               cmd_upper;
  logic [7:0]         out_char;
  logic               out_valid;
  logic [DEPTH_W-1:0] depth;
  logic               balanced;
  logic               err;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_upper,
    input  cmd_ready, out_char, out_valid, depth, balanced, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_upper,
    output cmd_ready, out_char, out_valid, depth, balanced, err
  );
endinterface

// File: rtl/block_stream_emitter.sv
// Serialises BEGIN/END/WORD tokens to ASCII (one char per cycle, space-separated) and tracks nesting depth.
// Optional BLOCK_EMITTER_UPPER_EN: honour cmd_upper for uppercase keywords.
//
// state   | meaning
// IDLE    | nothing on the link, ready for a command
// CHAR    | emitting token body character idx_q
// SEP     | emitting the trailing space, ready for the next command
module block_stream_emitter #(
  parameter int          DEPTH_W = 8,
  parameter logic [7:0]  WORD_CH = 8'h78
) (
  input logic                   clk,
  input logic                   reset,
  block_stream_emitter_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_CHAR, ST_SEP} state_t;

  localparam logic [1:0]         OP_BEGIN  = 2'b00;
  localparam logic [1:0]         OP_END    = 2'b01;
  localparam logic [1:0]         OP_NOP    = 2'b11;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [3:0]         len_q, len_d;
  logic               upper_q, upper_d;
  logic [3:0]         idx_q, idx_d;
  logic [7:0]         char_q, char_d;
  logic               valid_q, valid_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;
  logic               cmd_ready;
  logic               accept;
  logic               upper_in;
  logic [3:0]         last_idx;

`ifdef BLOCK_EMITTER_UPPER_EN
  assign upper_in = bus.cmd_upper;
`else
  assign upper_in = 1'b0;
`endif

  function automatic logic [7:0] body_char(input logic [1:0] op, input logic [3:0] idx,
                                           input logic up);
    logic [7:0] ch;
    ch = WORD_CH;
    if (op == OP_BEGIN) begin
      case (idx)
        4'd0:    ch = 8'h62;
        4'd1:    ch = 8'h65;
        4'd2:    ch = 8'h67;
        4'd3:    ch = 8'h69;
        default: ch = 8'h6e;
      endcase
    end else if (op == OP_END) begin
      case (idx)
        4'd0:    ch = 8'h65;
        4'd1:    ch = 8'h6e;
        default: ch = 8'h64;
      endcase
    end
    // Keyword letters only; WORD filler is never case-folded.
    if (up && (op == OP_BEGIN || op == OP_END)) ch = ch - 8'h20;
    return ch;
  endfunction

  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_SEP);
  assign accept    = bus.cmd_valid && cmd_ready;

  always_comb begin
    last_idx = 4'd0;
    case (op_q)
      OP_BEGIN: last_idx = 4'd4;
      OP_END:   last_idx = 4'd2;
      default:  last_idx = (len_q == 4'd0) ? 4'd0 : len_q - 4'd1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      len_q   <= '0;
      upper_q <= 1'b0;
      idx_q   <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      upper_q <= upper_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    upper_d = upper_q;
    idx_d   = idx_q;
    char_d  = char_q;
    valid_d = valid_q;
    depth_d = depth_q;
    err_d   = err_q;
    case (state_q)
      ST_CHAR: begin
        if (idx_q == last_idx) begin
          state_d = ST_SEP;
          char_d  = 8'h20;
          if (op_q == OP_BEGIN) begin
            if (depth_q == DEPTH_MAX) err_d = 1'b1;
            else depth_d = depth_q + 1'b1;
          end else if (op_q == OP_END) begin
            if (depth_q == '0) err_d = 1'b1;
            else depth_d = depth_q - 1'b1;
          end
        end else begin
          idx_d  = idx_q + 4'd1;
          char_d = body_char(op_q, idx_q + 4'd1, upper_q);
        end
      end
      default: begin
        if (accept) begin
          op_d    = bus.cmd_op;
          len_d   = bus.cmd_len;
          upper_d = upper_in;
          idx_d   = '0;
          if (bus.cmd_op == OP_NOP) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            char_d  = 8'h00;
          end else begin
            state_d = ST_CHAR;
            valid_d = 1'b1;
            char_d  = body_char(bus.cmd_op, 4'd0, upper_in);
          end
        end else begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          char_d  = 8'h00;
        end
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.out_char  = char_q;
  assign bus.out_valid = valid_q;
  assign bus.depth     = depth_q;
  assign bus.err       = err_q;
  assign bus.balanced  = (depth_q == '0) && !err_q;
endmodule

// File: tb/tb_block_stream_emitter.sv
// Self-checking bench for block_stream_emitter: directed and random token streams against a string-level model.
module tb_block_stream_emitter;
  typedef struct {
    logic [1:0] op;
    logic [3:0] len;
    logic       up;
    bit         gap;
  } tok_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       c_valid = 1'b0;
  logic [1:0] c_op = 2'b11;
  logic [3:0] c_len = 4'd0;
  logic       c_upper = 1'b0;
  bit         sel = 1'b0;

  block_stream_emitter_if #(.DEPTH_W(8)) bus8 ();
  block_stream_emitter_if #(.DEPTH_W(2)) bus2 ();

  block_stream_emitter #(.DEPTH_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));
  block_stream_emitter #(.DEPTH_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  assign bus8.cmd_valid = c_valid;
  assign bus8.cmd_op    = c_op;
  assign bus8.cmd_len   = c_len;
  assign bus8.cmd_upper = c_upper;
  assign bus2.cmd_valid = c_valid;
  assign bus2.cmd_op    = c_op;
  assign bus2.cmd_len   = c_len;
  assign bus2.cmd_upper = c_upper;

  logic [7:0] o_char, o_depth;
  logic       o_valid, o_ready, o_err, o_bal;
  assign o_char  = sel ? bus2.out_char  : bus8.out_char;
  assign o_valid = sel ? bus2.out_valid : bus8.out_valid;
  assign o_ready = sel ? bus2.cmd_ready : bus8.cmd_ready;
  assign o_err   = sel ? bus2.err       : bus8.err;
  assign o_bal   = sel ? bus2.balanced  : bus8.balanced;
  assign o_depth = sel ? {6'd0, bus2.depth} : bus8.depth;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   mdepth = 0;
  bit   merr = 1'b0;
  tok_t tq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string expect_str(input tok_t t);
    string s;
    int    n;
    s = "";
    case (t.op)
      2'b00: s = "begin";
      2'b01: s = "end";
      2'b10: begin
        n = (t.len == 4'd0) ? 1 : int'(t.len);
        for (int i = 0; i < n; i++) s = {s, "x"};
      end
      default: return "";
    endcase
`ifdef BLOCK_EMITTER_UPPER_EN
    if (t.up && t.op != 2'b10) s = s.toupper();
`endif
    return {s, " "};
  endfunction

  function automatic void model_finish(input logic [1:0] op);
    int dmax;
    dmax = sel ? 3 : 255;
    if (op == 2'b00) begin
      if (mdepth < dmax) mdepth++;
      else merr = 1'b1;
    end else if (op == 2'b01) begin
      if (mdepth > 0) mdepth--;
      else merr = 1'b1;
    end
  endfunction

  task automatic push(input logic [1:0] op, input logic [3:0] len, input logic up, input bit gap);
    tok_t t;
    t.op = op; t.len = len; t.up = up; t.gap = gap;
    tq.push_back(t);
  endtask

  // Called at a negedge with the emitter idle; offers queued tokens back-to-back.
  task automatic run_q();
    tok_t  t;
    string s;
    for (int i = 0; i < tq.size(); i++) begin
      t = tq[i];
      chk("ready_at_offer", 32'(o_ready), 32'd1);
      c_valid = 1'b1; c_op = t.op; c_len = t.len; c_upper = t.up;
      @(negedge clk);
      if (t.op == 2'b11) begin
        chk("nop_valid", 32'(o_valid), 32'd0);
        chk("nop_ready", 32'(o_ready), 32'd1);
        c_valid = 1'b0;
        continue;
      end
      s = expect_str(t);
      for (int j = 0; j < s.len(); j++) begin
        if (j > 0) @(negedge clk);
        chk("char", 32'(o_char), 32'(s[j]));
        chk("valid", 32'(o_valid), 32'd1);
        if (j < s.len() - 1) begin
          chk("busy_ready", 32'(o_ready), 32'd0);
          c_valid = 1'($urandom_range(0, 1));
          c_op    = 2'($urandom);
          c_len   = 4'($urandom);
        end else begin
          model_finish(t.op);
          chk("depth", 32'(o_depth), 32'(mdepth));
          chk("err", 32'(o_err), 32'(merr));
          chk("balanced", 32'(o_bal), 32'((mdepth == 0) && !merr));
          chk("sep_ready", 32'(o_ready), 32'd1);
          c_valid = 1'b0;
        end
      end
      if (t.gap) begin
        @(negedge clk);
        chk("gap_valid", 32'(o_valid), 32'd0);
        chk("gap_char", 32'(o_char), 32'd0);
      end
    end
    @(negedge clk);
    chk("end_valid", 32'(o_valid), 32'd0);
    chk("end_char", 32'(o_char), 32'd0);
    chk("end_ready", 32'(o_ready), 32'd1);
    tq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    c_valid = 1'b0;
    #1;
    mdepth = 0;
    merr = 1'b0;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_char", 32'(o_char), 32'd0);
    chk("rst_depth", 32'(o_depth), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_bal", 32'(o_bal), 32'd1);
    chk("rst_ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic random_tokens(input int n);
    for (int i = 0; i < n; i++)
      push(2'($urandom), 4'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
    run_q();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("init_valid", 32'(o_valid), 32'd0);
    chk("init_depth", 32'(o_depth), 32'd0);
    chk("init_bal", 32'(o_bal), 32'd1);
    chk("init_ready", 32'(o_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);

    push(2'b00, 4'd0, 1'b0, 1'b0);
    push(2'b01, 4'd0, 1'b0, 1'b0);
    run_q();

    push(2'b01, 4'd0, 1'b0, 1'b1);
    push(2'b00, 4'd0, 1'b0, 1'b0);
    push(2'b01, 4'd0, 1'b0, 1'b0);
    run_q();
    do_reset();

    push(2'b10, 4'd3, 1'b0, 1'b0);
    push(2'b10, 4'd0, 1'b0, 1'b0);
    push(2'b11, 4'd0, 1'b0, 1'b0);
    push(2'b10, 4'd15, 1'b1, 1'b1);
    push(2'b00, 4'd0, 1'b1, 1'b0);
    push(2'b01, 4'd0, 1'b1, 1'b0);
    run_q();

    // Reset in the middle of a BEGIN, with depth already non-zero.
    push(2'b00, 4'd0, 1'b0, 1'b0);
    run_q();
    c_valid = 1'b1; c_op = 2'b00; c_len = 4'd0; c_upper = 1'b0;
    @(negedge clk);
    chk("part_b", 32'(o_char), 32'h62);
    c_valid = 1'b0;
    @(negedge clk);
    chk("part_e", 32'(o_char), 32'h65);
    do_reset();
    push(2'b01, 4'd0, 1'b0, 1'b0);
    run_q();

    do_reset();
    random_tokens(40);

    sel = 1'b1;
    do_reset();
    repeat (4) push(2'b00, 4'd0, 1'b0, 1'b0);
    run_q();
    do_reset();
    random_tokens(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
